// File: rtl/hsk_cobs_encoder.sv
// hsk_cobs_encoder
// Streaming COBS framer for the housekeeping serial link. Raw packet bytes
// (delimited by s_tlast) are collected into a block buffer of up to 254
// nonzero bytes; each closed block is emitted as a code byte followed by its
// stored bytes, and every packet ends with a 0x00 delimiter.
//
// Optional feature macro: HSK_COBS_CKSUM_EN
//   When defined, an 8-bit running sum of the raw bytes at packet index
//   >= CKSUM_OFFSET is kept and its two's complement is appended internally
//   as the real final byte of the packet.
module hsk_cobs_encoder #(
  parameter int CKSUM_OFFSET = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready
);

  if (CKSUM_OFFSET < 0 || CKSUM_OFFSET > 255) begin : g_bad_cksum_offset
    $error("CKSUM_OFFSET must lie in 0..255");
  end

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CODE  = 2'd1,
    DATA  = 2'd2,
    DELIM = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [7:0] run, run_nx;
  logic [7:0] rd_ptr, rd_ptr_nx;
  logic       zero_term, zero_term_nx;
  logic       pkt_end, pkt_end_nx;
  logic       armed;
  logic       blk_done;
  logic       close_blk;

  // Byte presented to the block builder this cycle (external or injected)
  logic       in_fire;
  logic [7:0] in_byte;
  logic       in_last;

  logic [7:0] blk_buf [0:253];

`ifdef HSK_COBS_CKSUM_EN
  localparam logic [7:0] OFS = CKSUM_OFFSET[7:0];

  logic       inj_pend;
  logic [7:0] idx_cnt;
  logic [7:0] sum;

  assign s_tready = armed && (state == FILL) && !inj_pend;
  assign in_fire  = (armed && (state == FILL) && inj_pend) || (s_tvalid && s_tready);
  assign in_byte  = inj_pend ? (8'd0 - sum) : s_tdata;
  assign in_last  = inj_pend;

  // Checksum accumulation over the payload; the injected byte ends the packet
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inj_pend <= 1'b0;
      idx_cnt  <= 8'd0;
      sum      <= 8'd0;
    end else if ((state == FILL) && in_fire) begin
      if (inj_pend) begin
        inj_pend <= 1'b0;
        idx_cnt  <= 8'd0;
        sum      <= 8'd0;
      end else begin
        if (idx_cnt >= OFS) begin
          sum <= sum + s_tdata;
        end else begin
          idx_cnt <= idx_cnt + 8'd1;
        end
        if (s_tlast) begin
          inj_pend <= 1'b1;
        end
      end
    end
  end
`else
  assign s_tready = armed && (state == FILL);
  assign in_fire  = s_tvalid && s_tready;
  assign in_byte  = s_tdata;
  assign in_last  = s_tlast;
`endif

  // Block buffer write: only nonzero bytes are stored
  always_ff @(posedge clk) begin
    if ((state == FILL) && in_fire && (in_byte != 8'd0)) begin
      blk_buf[run] <= in_byte;
    end
  end

  // Control state register; armed holds s_tready low through reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      run       <= 8'd0;
      rd_ptr    <= 8'd0;
      zero_term <= 1'b0;
      pkt_end   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nx;
      run       <= run_nx;
      rd_ptr    <= rd_ptr_nx;
      zero_term <= zero_term_nx;
      pkt_end   <= pkt_end_nx;
      armed     <= 1'b1;
    end
  end

  // Next-state: block building, block emission and the next-block decision
  always_comb begin
    state_nx     = state;
    run_nx       = run;
    rd_ptr_nx    = rd_ptr;
    zero_term_nx = zero_term;
    pkt_end_nx   = pkt_end;
    blk_done     = 1'b0;
    close_blk    = 1'b0;

    case (state)
      FILL: begin
        if (in_fire) begin
          close_blk = (in_byte == 8'd0) || (run == 8'd253) || in_last;
          if (in_byte != 8'd0) begin
            run_nx = run + 8'd1;
          end
          if (close_blk) begin
            state_nx     = CODE;
            zero_term_nx = (in_byte == 8'd0);
            pkt_end_nx   = in_last;
          end
        end
      end
      CODE: begin
        if (m_tready) begin
          if (run != 8'd0) begin
            state_nx = DATA;
          end else begin
            blk_done = 1'b1;
          end
        end
      end
      DATA: begin
        if (m_tready) begin
          rd_ptr_nx = rd_ptr + 8'd1;
          if (rd_ptr == (run - 8'd1)) begin
            blk_done = 1'b1;
          end
        end
      end
      DELIM: begin
        if (m_tready) begin
          state_nx     = FILL;
          run_nx       = 8'd0;
          rd_ptr_nx    = 8'd0;
          zero_term_nx = 1'b0;
          pkt_end_nx   = 1'b0;
        end
      end
      default: state_nx = FILL;
    endcase

    // A packet whose last byte was a zero still owes the empty block (0x01)
    // that encodes that final zero before the delimiter.
    if (blk_done) begin
      if (!pkt_end) begin
        state_nx  = FILL;
        run_nx    = 8'd0;
        rd_ptr_nx = 8'd0;
      end else if (zero_term) begin
        state_nx     = CODE;
        run_nx       = 8'd0;
        rd_ptr_nx    = 8'd0;
        zero_term_nx = 1'b0;
      end else begin
        state_nx = DELIM;
      end
    end
  end

  // Output mux; depends only on registered state so it holds under stall
  always_comb begin
    m_tvalid = (state != FILL);
    case (state)
      CODE:    m_tdata = run + 8'd1;
      DATA:    m_tdata = blk_buf[rd_ptr];
      default: m_tdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_hsk_cobs_encoder.sv
// Testbench for hsk_cobs_encoder: scoreboard of expected encoded bytes,
// pushed when a packet is driven and popped at each output handshake.
module tb_hsk_cobs_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pkt_q[$];
  logic       rdy_mode = 1'b0;

  logic       stall_prev = 1'b0;
  logic [7:0] held_data  = 8'h00;
  logic [7:0] mon_e;

  hsk_cobs_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
  );

  always #5 clk = ~clk;

  // Downstream ready: always 1 or pseudo-random, changed just after posedge
  always @(posedge clk) begin
    #1;
    m_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard and stall-stability monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (stall_prev) begin
      n_vec++;
      if (m_tvalid !== 1'b1 || m_tdata !== held_data) begin
        n_err++;
        $display("FAIL stall_hold: got vld=%b data=%h, need vld=1 data=%h", m_tvalid, m_tdata, held_data);
      end
    end
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got %h, none expected", m_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_tdata !== mon_e) begin
          n_err++;
          $display("FAIL out_byte: got %h, expected %h", m_tdata, mon_e);
        end
      end
    end
    stall_prev = (m_tvalid === 1'b1) && (m_tready === 1'b0) && (rst_n === 1'b1);
    held_data  = m_tdata;
  end

  // Independent reference: textbook COBS encoding plus 0x00 delimiter
  task automatic push_model();
    logic [7:0] o[$];
    int idx;
    int code;
    int n;
    bit done;
    o.delete();
    o.push_back(8'h00);
    idx  = 0;
    code = 1;
    done = 1'b0;
    n    = pkt_q.size();
    for (int i = 0; i < n; i++) begin
      if (pkt_q[i] == 8'h00) begin
        o[idx] = 8'(code);
        idx    = o.size();
        o.push_back(8'h00);
        code   = 1;
      end else begin
        o.push_back(pkt_q[i]);
        code++;
        if (code == 255) begin
          o[idx] = 8'(code);
          if (i != n - 1) begin
            idx  = o.size();
            o.push_back(8'h00);
            code = 1;
          end else begin
            done = 1'b1;
          end
        end
      end
    end
    if (!done) o[idx] = 8'(code);
    o.push_back(8'h00);
    foreach (o[k]) exp_q.push_back(o[k]);
  endtask

  task automatic drive_pkt();
    int n;
    int wt;
    n = pkt_q.size();
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      s_tdata  = pkt_q[i];
      s_tlast  = (i == n - 1);
      s_tvalid = 1'b1;
      wt = 0;
      @(negedge clk);
      while (s_tready !== 1'b1 && wt < 3000) begin
        wt++;
        @(negedge clk);
      end
      if (s_tready !== 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL input_timeout: s_tready=%b at byte %0d, expected 1", s_tready, i);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d bytes still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec += 3;
    if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_s_tready: got %b, expected 0", s_tready); end
    if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_m_tvalid: got %b, expected 0", m_tvalid); end
    if (m_tdata !== 8'h00) begin n_err++; $display("FAIL rst_m_tdata: got %h, expected 00", m_tdata); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (s_tready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b, expected 1", s_tready); end
  endtask

`ifndef HSK_COBS_CKSUM_EN
  task automatic test_pingpong();
    logic [7:0] e [7] = '{8'h01, 8'h02, 8'h40, 8'h01, 8'h01, 8'h01, 8'h00};
    rdy_mode = 1'b0;
    pkt_q = {8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
    foreach (e[k]) exp_q.push_back(e[k]);
    drive_pkt();
    wait_drain(200);
  endtask

  task automatic test_pmbus_stall();
    logic [7:0] e [10] = '{8'h01, 8'h04, 8'h40, 8'hC1, 8'h03, 8'h04, 8'h20, 8'hD9, 8'h07, 8'h00};
    rdy_mode = 1'b1;
    pkt_q = {8'h00, 8'h40, 8'hC1, 8'h03, 8'h00, 8'h20, 8'hD9, 8'h07};
    foreach (e[k]) exp_q.push_back(e[k]);
    drive_pkt();
    wait_drain(500);
    rdy_mode = 1'b0;
  endtask

  task automatic test_zero_alone();
    rdy_mode = 1'b0;
    repeat (2) @(posedge clk);
    pkt_q = {8'h00};
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    drive_pkt();
    @(negedge clk);
    n_vec += 3;
    if (s_tready !== 1'b0) begin n_err++; $display("FAIL close_ready_drop: got %b, expected 0", s_tready); end
    if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL code_latency: m_tvalid got %b, expected 1", m_tvalid); end
    if (m_tdata !== 8'h01) begin n_err++; $display("FAIL code_latency_data: got %h, expected 01", m_tdata); end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'h00) begin
      n_err++;
      $display("FAIL delim_timing: got vld=%b data=%h, expected vld=1 data=00", m_tvalid, m_tdata);
    end
    @(negedge clk);
    n_vec += 2;
    if (s_tready !== 1'b1) begin n_err++; $display("FAIL return_fill_ready: got %b, expected 1", s_tready); end
    if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL return_fill_vld: got %b, expected 0", m_tvalid); end
    wait_drain(50);
    pkt_q = {8'h11, 8'h00};
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    drive_pkt();
    wait_drain(100);
  endtask

  task automatic test_max_block();
    int cnt;
    int guard;
    rdy_mode = 1'b0;
    // 01..FE as one packet: single FF block, no trailing 01
    pkt_q.delete();
    for (int i = 1; i <= 254; i++) pkt_q.push_back(8'(i));
    exp_q.push_back(8'hFF);
    for (int i = 1; i <= 254; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h00);
    drive_pkt();
    cnt = 0;
    guard = 0;
    while (guard < 600) begin
      @(negedge clk);
      guard++;
      if (m_tvalid === 1'b1) cnt++;
      else if (cnt > 0) break;
    end
    n_vec++;
    if (cnt != 256) begin n_err++; $display("FAIL max_block_cycles: got %0d, expected 256", cnt); end
    wait_drain(100);
    // 01..FF: FF block then a 2-byte block
    pkt_q.delete();
    for (int i = 1; i <= 255; i++) pkt_q.push_back(8'(i));
    exp_q.push_back(8'hFF);
    for (int i = 1; i <= 254; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    drive_pkt();
    wait_drain(800);
    // 01..FE then a final zero: FF block, then 01 01 before the delimiter
    pkt_q.delete();
    for (int i = 1; i <= 254; i++) pkt_q.push_back(8'(i));
    pkt_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    for (int i = 1; i <= 254; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    drive_pkt();
    wait_drain(800);
  endtask

  task automatic test_mid_reset();
    logic [7:0] part [3] = '{8'h40, 8'h11, 8'h22};
    logic [7:0] e [7] = '{8'h01, 8'h03, 8'h40, 8'h11, 8'h01, 8'h01, 8'h00};
    rdy_mode = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      s_tdata  = part[i];
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec += 2;
    if (s_tready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b, expected 0", s_tready); end
    if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_vld: got %b, expected 0", m_tvalid); end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    pkt_q = {8'h00, 8'h40, 8'h11, 8'h00, 8'h00};
    foreach (e[k]) exp_q.push_back(e[k]);
    drive_pkt();
    wait_drain(200);
  endtask

  task automatic test_random();
    int len;
    rdy_mode = 1'b1;
    for (int p = 0; p < 8; p++) begin
      pkt_q.delete();
      len = (p == 7) ? 600 : $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if (p == 7) pkt_q.push_back(($urandom_range(0, 99) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
        else pkt_q.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      end
      push_model();
      drive_pkt();
      wait_drain(6000);
    end
    rdy_mode = 1'b0;
  endtask
`else
  task automatic test_cksum();
    logic [7:0] e1 [10] = '{8'h01, 8'h04, 8'h40, 8'hC1, 8'h03, 8'h04, 8'h20, 8'hD9, 8'h07, 8'h00};
    logic [7:0] e2 [7]  = '{8'h01, 8'h03, 8'h40, 8'h11, 8'h01, 8'h01, 8'h00};
    rdy_mode = 1'b0;
    pkt_q = {8'h00, 8'h40, 8'hC1, 8'h03, 8'h00, 8'h20, 8'hD9};
    foreach (e1[k]) exp_q.push_back(e1[k]);
    drive_pkt();
    wait_drain(200);
    rdy_mode = 1'b1;
    pkt_q = {8'h00, 8'h40, 8'h11, 8'h00};
    foreach (e2[k]) exp_q.push_back(e2[k]);
    drive_pkt();
    wait_drain(400);
    rdy_mode = 1'b0;
  endtask
`endif

  initial begin
    m_tready = 1'b1;
    test_reset();
`ifndef HSK_COBS_CKSUM_EN
    test_pingpong();
    test_pmbus_stall();
    test_zero_alone();
    test_max_block();
    test_mid_reset();
    test_random();
`else
    test_cksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hsk_cobs_encoder.md
# hsk_cobs_encoder

Streaming COBS framer for the housekeeping (HSK) serial link. It takes raw housekeeping packet bytes, each packet delimited by `s_tlast`, and emits the COBS-encoded byte stream terminated by a 0x00 delimiter. The output is written directly into the `uart_tx6` transmit buffer that drives `HSK_TX`. It is the transmit-side counterpart of the COBS packet decode on the `HSK_RX` path.

## Interface
Parameters:
- `CKSUM_OFFSET`, default 4: number of header bytes (src, dst, cmd, len) excluded from the checksum. Used only with `HSK_COBS_CKSUM_EN`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk` in 1: system clock, 80 MHz.
- `rst_n` in 1: synchronous, active-low reset.
- `s_tdata` in 8: raw packet byte.
- `s_tvalid` in 1: input byte valid.
- `s_tready` out 1: input byte accepted when `s_tvalid && s_tready`.
- `s_tlast` in 1: marks the final raw byte of a packet.
- `m_tdata` out 8: encoded byte.
- `m_tvalid` out 1: encoded byte valid.
- `m_tready` in 1: downstream accept. Tie to `!buffer_full` of `uart_tx6`; `buffer_write = m_tvalid && m_tready`.

## Operation
- Block buffer: 254×8 distributed RAM with an asynchronous read. `run` counter is 8 bits (0..254); `rd_ptr` is 8 bits.
- State FILL (`s_tready = 1`). On each accepted byte:
  - Nonzero byte: write it to `buf[run]`, then `run++`.
  - Zero byte: close the block with `zero_term = 1`. The byte is not stored.
  - If a nonzero write makes `run == 254`, close the block with `zero_term = 0` (code 0xFF, no implied zero).
  - If the accepted byte has `s_tlast`, set `pkt_end = 1` and close the block.
- State CODE (`s_tready = 0`): `m_tdata = run + 1`. On handshake, go to DATA if `run != 0`; otherwise go to the next-block decision.
- State DATA: `m_tdata = buf[rd_ptr]`. On each handshake `rd_ptr++`. After the byte at `rd_ptr == run-1` completes, go to the next-block decision.
- Next-block decision (combinational, on exit from CODE/DATA):
  - `pkt_end == 0`: clear `run` and `rd_ptr`, go to FILL.
  - `pkt_end == 1` and the closed block was zero-terminated by the final byte: emit a trailing empty block (code 0x01, i.e. a CODE pass with `run = 0`), then DELIM.
  - `pkt_end == 1` otherwise: go to DELIM. This covers a final 0xFF block, which gets no extra 0x01.
- State DELIM: `m_tdata = 0x00`. On handshake, clear all state and go to FILL.
- `m_tdata` and `m_tvalid` are held stable while `m_tvalid && !m_tready`.
- A zero-length packet is impossible: a packet always carries at least the byte that has `s_tlast`.

## Timing
- Reset values: `s_tready = 0`, `m_tvalid = 0`, `m_tdata = 0x00`, state = FILL, `run = 0`, `pkt_end = 0`.
- `s_tready` rises on the first cycle after `rst_n` returns high.
- Input throughput: one byte per cycle in FILL.
- `s_tready` drops in the cycle immediately after the byte that closes a block is accepted.
- Close-to-output latency: `m_tvalid` rises with the code byte 1 cycle after the closing byte is accepted.
- With `m_tready` held high, a block of n stored bytes costs 1 + n output cycles; the delimiter costs 1 more cycle. There are no bubbles between encoded bytes within a packet.
- Return to FILL: the cycle after the last handshake of a block (or of the delimiter); `s_tready` is 1 in that cycle.
- Reset mid-packet: the partial block is discarded and no delimiter is emitted. The receiver resynchronises on the next 0x00.
- `m_tvalid` never asserts with `m_tdata == 0x00` except in DELIM.

## Configuration
- `HSK_COBS_CKSUM_EN` defined:
  - The encoder keeps an 8-bit running sum of the raw bytes at packet index ≥ `CKSUM_OFFSET`.
  - The input `s_tlast` byte is not treated as final. The encoder then injects one extra raw byte, `(-sum) & 0xFF`, internally with `pkt_end` set. `s_tready` is 0 during that injection cycle.
  - A packet shorter than or equal to `CKSUM_OFFSET` bytes gets a checksum byte of 0x00.
- `HSK_COBS_CKSUM_EN` undefined: bytes pass through verbatim; the upstream source supplies the checksum. The index counter and sum logic are not built.

## Test plan
- ePingPong: raw `00 40 00 00 00` (last on the final byte), `m_tready = 1` → output `01 02 40 01 01 01 00`, with no gaps after the first code byte.
- ePMBus: raw `00 40 C1 03 00 20 D9 07`, with `m_tready` toggling 1/0 pseudo-randomly → output `01 04 40 C1 03 04 20 D9 07 00`, and `m_tdata` held stable while stalled.
- 254 nonzero bytes `01..FE` as one packet → `FF 01..FE 00` (no 0x01 before the delimiter). Then bytes `01..FF` (255 bytes) → `FF 01..FE 02 FF 00`.
- Zero handling: raw `00` alone → `01 01 00`. Raw `11 00` → `02 11 01 00`. After the 254-byte FF block, a following 0x00 as the last byte → `... FF <254 bytes> 01 01 00`.
- Reset mid-packet:
  - Drive 3 bytes of `40 11 22` (no last), then pull `rst_n` low for 1 cycle → no output, and `s_tready = 0` during reset.
  - Then send the eVolts packet `00 40 11 00 00` → exactly `01 03 40 11 01 01 00`.
- With `HSK_COBS_CKSUM_EN`:
  - Raw `00 40 C1 03 00 20 D9` (last on D9) → `01 04 40 C1 03 04 20 D9 07 00`.
  - Raw `00 40 11 00` → `01 03 40 11 01 01 00`.
